// File: rtl/run_done_if.sv
// Instruction-stream / status bundle between the processor front end and run_done_controller.
// The timeout wire exists only when RUN_WATCHDOG_EN is defined.
interface run_done_if #(
    parameter int CYCLE_W  = 32,
    parameter int OPCODE_W = 4
);
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                vec_busy;
    logic                run_en;
    logic                Done;
    logic [CYCLE_W-1:0]  cycle_count;
    logic [CYCLE_W-1:0]  instr_count;
`ifdef RUN_WATCHDOG_EN
    logic                timeout;
`endif

    modport master (
        output instr_valid,
        output opcode,
        output vec_busy,
        input  run_en,
        input  Done,
        input  cycle_count,
        input  instr_count
`ifdef RUN_WATCHDOG_EN
        , input timeout
`endif
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        input  vec_busy,
        output run_en,
        output Done,
        output cycle_count,
        output instr_count
`ifdef RUN_WATCHDOG_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/run_done_controller.sv
// Run/halt sequencer: START -> RUN -> DRAIN -> DONE with saturating cycle/instruction counters.
// Optional watchdog (MAX_CYCLES limit, timeout output) is built when RUN_WATCHDOG_EN is defined.
module run_done_controller #(
    parameter int                  CYCLE_W      = 32,
    parameter int                  OPCODE_W     = 4,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE  = 4'hF,
    parameter int                  DRAIN_CYCLES = 2
`ifdef RUN_WATCHDOG_EN
    , parameter int                MAX_CYCLES   = 100000
`endif
) (
    input logic       clk,
    input logic       reset,
    run_done_if.slave bus
);
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int               DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_s;
    logic [CYCLE_W-1:0] cycle_r;
    logic [CYCLE_W-1:0] cycle_s;
    logic [CYCLE_W-1:0] instr_r;
    logic [CYCLE_W-1:0] instr_s;
    logic [DRAIN_W-1:0] drain_r;
    logic [DRAIN_W-1:0] drain_s;
    logic               run_en_r;
    logic               done_r;
    logic               timeout_r;
    logic               timeout_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CYCLE_W'(1);
        end
    endfunction

    // Next-state and counter update logic.
    always_comb begin
        state_s   = state_r;
        cycle_s   = cycle_r;
        instr_s   = instr_r;
        drain_s   = drain_r;
        timeout_s = timeout_r;
        case (state_r)
            ST_START: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                cycle_s = sat_inc(cycle_r);
                if (bus.instr_valid) begin
                    instr_s = sat_inc(instr_r);
                    if (bus.opcode == HALT_OPCODE) begin
                        state_s = ST_DRAIN;
                        drain_s = {DRAIN_W{1'b0}};
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                cycle_s = sat_inc(cycle_r);
                if (drain_r == DRAIN_LAST) begin
                    drain_s = drain_r;
                end else begin
                    drain_s = drain_r + DRAIN_W'(1);
                end
                // Exit only once the minimum drain time has elapsed and the vector unit is idle.
                if ((drain_r == DRAIN_LAST) && !bus.vec_busy) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_START;
            end
        endcase
`ifdef RUN_WATCHDOG_EN
        // Watchdog overrides any other transition, including a coincident halt.
        if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
            (cycle_r == CYCLE_W'(MAX_CYCLES - 1))) begin
            cycle_s   = CYCLE_W'(MAX_CYCLES);
            state_s   = ST_DONE;
            timeout_s = 1'b1;
        end else begin
            timeout_s = timeout_s;
        end
`endif
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_START;
            cycle_r   <= {CYCLE_W{1'b0}};
            instr_r   <= {CYCLE_W{1'b0}};
            drain_r   <= {DRAIN_W{1'b0}};
            run_en_r  <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cycle_r   <= cycle_s;
            instr_r   <= instr_s;
            drain_r   <= drain_s;
            run_en_r  <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
            timeout_r <= timeout_s;
        end
    end

    assign bus.run_en      = run_en_r;
    assign bus.Done        = done_r;
    assign bus.cycle_count = cycle_r;
    assign bus.instr_count = instr_r;
`ifdef RUN_WATCHDOG_EN
    assign bus.timeout     = timeout_r;
`endif

endmodule

// File: tb/tb_run_done_controller.sv
// Self-checking bench for run_done_controller: directed scenarios with randomized fetch/busy
// patterns; expected counts derived from the run/drain rules with plain arithmetic.
module tb_run_done_controller;
    localparam int         CW    = 32;
    localparam int         DRAIN = 2;
    localparam int         MAXC  = 50;
    localparam logic [3:0] HALT  = 4'hF;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    run_done_if #(.CYCLE_W(CW), .OPCODE_W(4)) bus ();

    run_done_controller #(
        .CYCLE_W(CW),
        .OPCODE_W(4),
        .HALT_OPCODE(HALT),
        .DRAIN_CYCLES(DRAIN)
`ifdef RUN_WATCHDOG_EN
        , .MAX_CYCLES(MAXC)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_random();
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.opcode      = 4'($urandom_range(0, 15));
        bus.vec_busy    = 1'($urandom_range(0, 1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_run_en"}, 32'(bus.run_en), 32'd0);
        chk({tag, "_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_cyc"}, bus.cycle_count, 32'd0);
        chk({tag, "_ins"}, bus.instr_count, 32'd0);
`ifdef RUN_WATCHDOG_EN
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
`endif
    endtask

    // Reset for two cycles with random inputs, release, and take the START edge.
    task automatic do_reset();
        reset = 1'b0;
        drive_random();
        #1;
        check_zero("rst_async");
        repeat (2) begin
            @(posedge clk); #1;
            drive_random();
            check_zero("rst_hold");
        end
        reset = 1'b1;
        bus.instr_valid = 1'b1;
        bus.opcode      = HALT;
        #1;
        check_zero("rst_released");
        @(posedge clk); #1;
        chk("start_run_en", 32'(bus.run_en), 32'd1);
        chk("start_done", 32'(bus.Done), 32'd0);
        chk("start_cyc", bus.cycle_count, 32'd0);
        chk("start_ins", bus.instr_count, 32'd0);
    endtask

    // One program: RUN until the halt_idx-th valid fetch, then DRAIN, then hold in DONE.
    task automatic run_prog(input int halt_idx, input int gap_mode, input int busy_extra,
                            input bit busy_rand, input int hold, input bit abort,
                            output int n_cyc, output int n_ins);
        int nrun;
        int nval;
        int exit_k;
        bit valid;
        bit halted;
        bit busy [64];
        nrun   = 0;
        nval   = 0;
        halted = 1'b0;
        while (!halted && nrun < 500) begin
            case (gap_mode)
                0:       valid = 1'b1;
                1:       valid = (nrun % 2 == 0);
                default: valid = (nrun >= 2 * halt_idx) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            bus.instr_valid = valid;
            bus.vec_busy    = 1'($urandom_range(0, 1));
            if (valid) begin
                bus.opcode = (nval + 1 == halt_idx) ? HALT : 4'($urandom_range(0, 14));
            end else begin
                bus.opcode = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            nrun++;
            if (valid) nval++;
            halted = valid && (nval == halt_idx);
            chk("run_cyc", bus.cycle_count, 32'(nrun));
            chk("run_ins", bus.instr_count, 32'(nval));
            chk("run_en", 32'(bus.run_en), halted ? 32'd0 : 32'd1);
            chk("run_done", 32'(bus.Done), 32'd0);
        end
        for (int k = 0; k < 64; k++) begin
            busy[k] = busy_rand ? ((k < 16) && ($urandom_range(0, 2) != 0)) : (k < DRAIN + busy_extra);
        end
        exit_k = 0;
        for (int k = 1; k < 64; k++) begin
            if (exit_k == 0 && k >= DRAIN && !busy[k]) exit_k = k;
        end
        for (int k = 1; k <= exit_k; k++) begin
            bus.vec_busy    = busy[k];
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.opcode      = ($urandom_range(0, 1) == 0) ? HALT : 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("drain_cyc", bus.cycle_count, 32'(nrun + k));
            chk("drain_ins", bus.instr_count, 32'(nval));
            chk("drain_run_en", 32'(bus.run_en), 32'd0);
            chk("drain_done", 32'(bus.Done), (k == exit_k) ? 32'd1 : 32'd0);
            if (abort && k == 1) begin
                #2;
                reset = 1'b0;
                #1;
                check_zero("abort_async");
                @(posedge clk); #1;
                check_zero("abort_hold");
                n_cyc = 0;
                n_ins = 0;
                return;
            end
        end
        repeat (hold) begin
            drive_random();
            @(posedge clk); #1;
            chk("done_done", 32'(bus.Done), 32'd1);
            chk("done_run_en", 32'(bus.run_en), 32'd0);
            chk("done_cyc", bus.cycle_count, 32'(nrun + exit_k));
            chk("done_ins", bus.instr_count, 32'(nval));
`ifdef RUN_WATCHDOG_EN
            chk("done_timeout", 32'(bus.timeout), 32'd0);
`endif
        end
        n_cyc = nrun + exit_k;
        n_ins = nval;
    endtask

    // Program that never halts: watchdog stop when built in, endless RUN otherwise.
    task automatic never_halt();
        int nval;
        bit valid;
        nval = 0;
        for (int i = 1; i <= 200; i++) begin
            valid           = 1'($urandom_range(0, 1));
            bus.instr_valid = valid;
            bus.opcode      = 4'($urandom_range(0, 14));
            bus.vec_busy    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
`ifdef RUN_WATCHDOG_EN
            if (valid && i <= MAXC) nval++;
            chk("wd_cyc", bus.cycle_count, 32'((i < MAXC) ? i : MAXC));
            chk("wd_ins", bus.instr_count, 32'(nval));
            chk("wd_run_en", 32'(bus.run_en), (i < MAXC) ? 32'd1 : 32'd0);
            chk("wd_done", 32'(bus.Done), (i >= MAXC) ? 32'd1 : 32'd0);
            chk("wd_timeout", 32'(bus.timeout), (i >= MAXC) ? 32'd1 : 32'd0);
`else
            if (valid) nval++;
            chk("nh_cyc", bus.cycle_count, 32'(i));
            chk("nh_ins", bus.instr_count, 32'(nval));
            chk("nh_run_en", 32'(bus.run_en), 32'd1);
            chk("nh_done", 32'(bus.Done), 32'd0);
`endif
        end
    endtask

    initial begin
        int c;
        int n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive_random();

        do_reset();
        run_prog(5, 0, 0, 1'b0, 5, 1'b0, c, n);
        chk("basic_cyc", bus.cycle_count, 32'd7);
        chk("basic_ins", bus.instr_count, 32'd5);

        do_reset();
        run_prog(5, 0, 4, 1'b0, 5, 1'b0, c, n);
        chk("stall_cyc", bus.cycle_count, 32'd11);
        chk("stall_ins", bus.instr_count, 32'd5);

        do_reset();
        run_prog(3, 1, 0, 1'b0, 25, 1'b0, c, n);
        chk("gaps_ins", bus.instr_count, 32'd3);
        chk("gaps_cyc", bus.cycle_count, 32'd7);

        do_reset();
        run_prog(4, 2, 3, 1'b0, 0, 1'b1, c, n);

        do_reset();
        run_prog(5, 0, 0, 1'b0, 3, 1'b0, c, n);
        chk("rerun_cyc", bus.cycle_count, 32'd7);
        chk("rerun_ins", bus.instr_count, 32'd5);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            run_prog(int'($urandom_range(1, 8)), 2, 0, 1'b1, int'($urandom_range(1, 6)), 1'b0, c, n);
        end

        do_reset();
        never_halt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
